// File: rtl/io_stage.sv
// ---------------------------------------------------------------------------
// io_stage : memory-access (IO) stage of the five-stage MIPS pipeline.
//
// Sits between ex_stage and the write-back stage. It latches the EX-to-IO
// bus, captures the synchronous data-SRAM read word during the single cycle
// it is presented, and keeps that word across write-back stalls. The final
// result (ALU result or load data) is forwarded to write-back and is also
// driven back to ID for bypassing and hazard detection.
//
// Ports:
//   clock                   rising-edge clock
//   reset                   asynchronous, active-low reset
//   wb_allow_in             write-back can accept an instruction this cycle
//   io_allow_in             this stage accepts from EX this cycle
//   ex_to_io_bus            payload from EX (valid, pc, alu result, dest,
//                           register write enable, result-from-memory flag)
//   data_read_data          data-SRAM read word, meaningful only in the
//                           first cycle an instruction occupies this stage
//   io_to_wb_bus            payload to write-back
//   io_to_id_back_pass_bus  bypass / hazard information for ID
// ---------------------------------------------------------------------------

package ex_stage_params;

    typedef struct packed {
        logic        valid;
        logic [31:0] program_count;
        logic [31:0] alu_result;
        logic [4:0]  destination_register;
        logic        register_write;
        logic        result_is_from_memory;
    } EXToIOData;

endpackage

package io_stage_params;

    typedef struct packed {
        logic        valid;
        logic [31:0] program_count;
        logic [31:0] final_result;
        logic [4:0]  destination_register;
        logic        register_write;
    } IOToWBData;

    typedef struct packed {
        logic        valid;
        logic [4:0]  write_register;
        logic [31:0] write_data;
    } IOToIDBackPassData;

endpackage

module io_stage (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 wb_allow_in,
    output logic                                 io_allow_in,
    input  ex_stage_params::EXToIOData           ex_to_io_bus,
    input  logic [31:0]                          data_read_data,
    output io_stage_params::IOToWBData           io_to_wb_bus,
    output io_stage_params::IOToIDBackPassData   io_to_id_back_pass_bus
);

    logic        io_valid;
    logic        first_cycle;
    logic [31:0] load_data_hold;

    logic [31:0] payload_program_count;
    logic [31:0] payload_alu_result;
    logic [4:0]  payload_destination;
    logic        payload_register_write;
    logic        payload_from_memory;

    logic        io_ready_go;
    logic        load_new;
    logic [31:0] load_data;
    logic [31:0] final_result;

    // The SRAM word is either live or already held, so this stage never
    // needs more than one cycle.
    assign io_ready_go = 1'b1;
    assign io_allow_in = !io_valid || (io_ready_go && wb_allow_in);
    assign load_new    = io_allow_in && ex_to_io_bus.valid;

    // Occupancy flag: it only changes when the stage is allowed to take
    // from EX, so a bubble from EX empties the stage while a WB stall
    // keeps the current instruction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_valid <= 1'b0;
        end else if (io_allow_in) begin
            io_valid <= ex_to_io_bus.valid;
        end
    end

    // Payload register. A bubble leaves the old payload untouched, so only
    // a valid incoming instruction overwrites it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            payload_program_count  <= 32'h0;
            payload_alu_result     <= 32'h0;
            payload_destination    <= 5'd0;
            payload_register_write <= 1'b0;
            payload_from_memory    <= 1'b0;
        end else if (load_new) begin
            payload_program_count  <= ex_to_io_bus.program_count;
            payload_alu_result     <= ex_to_io_bus.alu_result;
            payload_destination    <= ex_to_io_bus.destination_register;
            payload_register_write <= ex_to_io_bus.register_write;
            payload_from_memory    <= ex_to_io_bus.result_is_from_memory;
        end
    end

    // first_cycle marks the one cycle in which the SRAM output belongs to
    // the current instruction. A back-to-back replacement re-asserts it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            first_cycle <= 1'b0;
        end else begin
            first_cycle <= load_new;
        end
    end

    // Capture the SRAM word before it becomes undefined. Captured for every
    // instruction, loads or not, which keeps the enable trivially simple.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_data_hold <= 32'h0;
        end else if (io_valid && first_cycle) begin
            load_data_hold <= data_read_data;
        end
    end

    // Result selection: live SRAM data in the first cycle, held data after.
    always_comb begin
        load_data    = first_cycle ? data_read_data : load_data_hold;
        final_result = payload_from_memory ? load_data : payload_alu_result;
    end

    // Output buses. The back-pass is purely combinational so ID sees the
    // forwarded value in the same cycle; its register field is zeroed for
    // bubbles and non-writing instructions.
    always_comb begin
        io_to_wb_bus                      = '0;
        io_to_wb_bus.valid                = io_valid && io_ready_go;
        io_to_wb_bus.program_count        = payload_program_count;
        io_to_wb_bus.final_result         = final_result;
        io_to_wb_bus.destination_register = payload_destination;
        io_to_wb_bus.register_write       = payload_register_write;

        io_to_id_back_pass_bus                = '0;
        io_to_id_back_pass_bus.valid          = 1'b1;
        io_to_id_back_pass_bus.write_register =
            {5{payload_register_write && io_valid}} & payload_destination;
        io_to_id_back_pass_bus.write_data     = final_result;
    end

endmodule
